// File: rtl/demux_pkg.sv
// Shared definitions for the demux select sequencer: channel count, FSM
// state encodings, one-hot select constants and a channel-search helper.
package demux_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WRAP = 2'b10
  } state_t;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_CH0  = 4'b0001;
  localparam logic [3:0] SEL_CH1  = 4'b0010;
  localparam logic [3:0] SEL_CH2  = 4'b0100;
  localparam logic [3:0] SEL_CH3  = 4'b1000;

  // Lowest unmasked channel index >= start; bit 2 flags that one exists.
  function automatic logic [2:0] find_ch(input logic [2:0] start, input logic [3:0] mask);
    logic [2:0] res;
    res = 3'b000;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      res = ((i >= int'(start)) && !mask[i]) ? {1'b1, i[1:0]} : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/onehot_enc_v.sv
// Converts a 2-bit channel pointer plus enable into a one-hot demux select;
// disabled yields no channel.
module onehot_enc_v
  import demux_pkg::*;
(
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] sel
);

  // Pointer decode, gated by enable.
  always_comb begin
    sel = SEL_NONE;
    if (en) begin
      case (ptr)
        2'd0:    sel = SEL_CH0;
        2'd1:    sel = SEL_CH1;
        2'd2:    sel = SEL_CH2;
        2'd3:    sel = SEL_CH3;
        default: sel = SEL_NONE;
      endcase
    end else begin
      sel = SEL_NONE;
    end
  end

endmodule

// File: rtl/demux_sel_seq_v.sv
// Sequences accepted beats across four demux channels, a programmable dwell
// per channel. Optional channel skipping via macro DEMUX_SEL_SEQ_SKIP_EN.
module demux_sel_seq_v
  import demux_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_valid,
  input  logic               i_data,
`ifdef DEMUX_SEL_SEQ_SKIP_EN
  input  logic [3:0]         i_skip_mask,
`endif
  output logic               o_ready,
  output logic               o_a,
  output logic [3:0]         o_sel_code,
  output logic               o_vld,
  output logic               o_wrap
);

  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1'b1);
  localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};

  state_t             state_r, state_n_s;
  logic [1:0]         ptr_r, ptr_n_s;
  logic [DWELL_W-1:0] cnt_r, cnt_n_s;
  logic [DWELL_W-1:0] dwell_r, dwell_n_s, dwell_eff_s;
  logic [3:0]         mask_r, mask_n_s, skip_mask_s;
  logic [2:0]         first_ch_s, next_ch_s;
  logic               accept_s;
  logic               dwell_done_s;
  logic [3:0]         sel_s;

`ifdef DEMUX_SEL_SEQ_SKIP_EN
  assign skip_mask_s = i_skip_mask;
`else
  assign skip_mask_s = 4'b0000;
`endif

  // A dwell of zero behaves as one; the counter only reaches dwell-1, so all-ones never overflows.
  assign dwell_eff_s  = (i_dwell == DWELL_ZERO) ? DWELL_ONE : i_dwell;
  assign accept_s     = i_valid & o_ready;
  assign dwell_done_s = (cnt_r == (dwell_r - DWELL_ONE));
  assign first_ch_s   = find_ch(3'd0, skip_mask_s);
  assign next_ch_s    = find_ch({1'b0, ptr_r} + 3'd1, mask_r);

  onehot_enc_v u_enc (
    .ptr (ptr_r),
    .en  (accept_s),
    .sel (sel_s)
  );

  // Next-state, pointer, counter and latched-configuration logic.
  always_comb begin
    state_n_s = state_r;
    ptr_n_s   = ptr_r;
    cnt_n_s   = cnt_r;
    dwell_n_s = dwell_r;
    mask_n_s  = mask_r;
    case (state_r)
      ST_IDLE: begin
        cnt_n_s = DWELL_ZERO;
        if (i_en && first_ch_s[2]) begin
          state_n_s = ST_RUN;
          ptr_n_s   = first_ch_s[1:0];
          dwell_n_s = dwell_eff_s;
          mask_n_s  = skip_mask_s;
        end else begin
          state_n_s = ST_IDLE;
          ptr_n_s   = 2'd0;
        end
      end
      ST_RUN: begin
        if (!i_en) begin
          state_n_s = ST_IDLE;
          ptr_n_s   = 2'd0;
          cnt_n_s   = DWELL_ZERO;
        end else if (accept_s && dwell_done_s) begin
          cnt_n_s = DWELL_ZERO;
          if (next_ch_s[2]) begin
            ptr_n_s = next_ch_s[1:0];
          end else begin
            state_n_s = ST_WRAP;
            ptr_n_s   = 2'd0;
          end
        end else if (accept_s) begin
          cnt_n_s = cnt_r + DWELL_ONE;
        end else begin
          state_n_s = ST_RUN;
        end
      end
      ST_WRAP: begin
        cnt_n_s   = DWELL_ZERO;
        dwell_n_s = dwell_eff_s;
        mask_n_s  = skip_mask_s;
        if (i_en && first_ch_s[2]) begin
          state_n_s = ST_RUN;
          ptr_n_s   = first_ch_s[1:0];
        end else begin
          state_n_s = ST_IDLE;
          ptr_n_s   = 2'd0;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        ptr_n_s   = 2'd0;
        cnt_n_s   = DWELL_ZERO;
      end
    endcase
  end

  // State and registered outputs; outputs follow the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 2'd0;
      cnt_r      <= DWELL_ZERO;
      dwell_r    <= DWELL_ONE;
      mask_r     <= 4'b0000;
      o_ready    <= 1'b0;
      o_a        <= 1'b0;
      o_sel_code <= SEL_NONE;
      o_vld      <= 1'b0;
      o_wrap     <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      ptr_r      <= ptr_n_s;
      cnt_r      <= cnt_n_s;
      dwell_r    <= dwell_n_s;
      mask_r     <= mask_n_s;
      o_ready    <= (state_n_s == ST_RUN);
      o_a        <= accept_s & i_data;
      o_sel_code <= sel_s;
      o_vld      <= accept_s;
      o_wrap     <= (state_n_s == ST_WRAP);
    end
  end

endmodule

// File: tb/tb_demux_sel_seq_v.sv
// Directed self-checking bench for demux_sel_seq_v; the skip-mask scenario
// runs only when DEMUX_SEL_SEQ_SKIP_EN is defined.
module tb_demux_sel_seq_v;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en = 1'b0;
  logic [3:0] i_dwell = 4'd1;
  logic       i_valid = 1'b0;
  logic       i_data = 1'b0;
`ifdef DEMUX_SEL_SEQ_SKIP_EN
  logic [3:0] i_skip_mask = 4'b0000;
`endif
  logic       o_ready, o_a, o_vld, o_wrap;
  logic [3:0] o_sel_code;
  logic [7:0] obs;

  int total = 0;
  int bad = 0;

  demux_sel_seq_v #(.DWELL_W(4)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_dwell    (i_dwell),
    .i_valid    (i_valid),
    .i_data     (i_data),
`ifdef DEMUX_SEL_SEQ_SKIP_EN
    .i_skip_mask(i_skip_mask),
`endif
    .o_ready    (o_ready),
    .o_a        (o_a),
    .o_sel_code (o_sel_code),
    .o_vld      (o_vld),
    .o_wrap     (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  // Observed vector: {ready, vld, wrap, a, sel[3:0]}
  assign obs = {o_ready, o_vld, o_wrap, o_a, o_sel_code};

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_data = 1'b0;
    step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    i_rst = 1'b1; i_en = 1'b1; i_valid = 1'b1; i_data = 1'b1;
    step();
    step();
    exp = 8'b0000_0000;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_hold: got %b want %b", obs, exp); end
    i_rst = 1'b0;
    step();
    exp = 8'b1000_0000;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_release: got %b want %b", obs, exp); end
  endtask

  task automatic test_sequence();
    logic [7:0] exp;
    logic [7:0] dpat;
    logic [3:0] one;
    dpat = 8'b0100_1101;
    one = 4'b0001;
    do_reset();
    i_dwell = 4'd2; i_en = 1'b1; i_valid = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      if (k == 3) i_dwell = 4'd7;
      if (k == 6) i_dwell = 4'd2;
      i_data = dpat[k];
      step();
      exp = {(k != 7), 1'b1, (k == 7), dpat[k], one << (k / 2)};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL seq_beat%0d: got %b want %b", k, obs, exp); end
    end
    i_dwell = 4'd3; i_data = 1'b1;
    step();
    exp = 8'b1000_0000;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_after_wrap: got %b want %b", obs, exp); end
    for (int k = 0; k < 4; k++) begin
      step();
      exp = {4'b1101, (k < 3) ? 4'b0001 : 4'b0010};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL seq_relatch%0d: got %b want %b", k, obs, exp); end
    end
    i_en = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_dwell_zero();
    logic [7:0] exp;
    logic [3:0] one;
    int m;
    one = 4'b0001;
    do_reset();
    i_dwell = 4'd0; i_en = 1'b1; i_valid = 1'b1; i_data = 1'b1;
    step();
    for (int c = 0; c < 15; c++) begin
      step();
      m = c % 5;
      exp = {(m != 3), (m < 4), (m == 3), (m < 4), (m < 4) ? (one << m) : 4'b0000};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL dwell0_cyc%0d: got %b want %b", c, obs, exp); end
    end
    i_en = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_gapped();
    logic [7:0] exp;
    logic [3:0] vpat;
    logic [3:0] dpat;
    vpat = 4'b1001;
    dpat = 4'b0111;
    do_reset();
    i_dwell = 4'd2; i_en = 1'b1; i_valid = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      i_valid = vpat[k]; i_data = dpat[k];
      step();
      exp = {1'b1, vpat[k], 1'b0, vpat[k] & dpat[k], vpat[k] ? 4'b0001 : 4'b0000};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL gap_cyc%0d: got %b want %b", k, obs, exp); end
    end
    i_valid = 1'b1; i_data = 1'b1;
    step();
    exp = 8'b1101_0010;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL gap_next_ch: got %b want %b", obs, exp); end
    i_en = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [7:0] exp;
    do_reset();
    i_dwell = 4'd1; i_en = 1'b1; i_valid = 1'b1; i_data = 1'b0;
    step();
    step();
    exp = 8'b1100_0001;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL endrop_ch0: got %b want %b", obs, exp); end
    i_en = 1'b0; i_data = 1'b1;
    step();
    exp = 8'b0101_0010;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL endrop_ch1: got %b want %b", obs, exp); end
    step();
    exp = 8'b0000_0000;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL endrop_idle: got %b want %b", obs, exp); end
    i_en = 1'b1;
    step();
    step();
    exp = 8'b1101_0001;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL endrop_restart: got %b want %b", obs, exp); end
    i_en = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp;
    do_reset();
    i_dwell = 4'd2; i_en = 1'b1; i_valid = 1'b1; i_data = 1'b1;
    step();
    for (int k = 0; k < 5; k++) step();
    exp = 8'b1101_0100;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL midrun_pre: got %b want %b", obs, exp); end
    i_rst = 1'b1;
    step();
    exp = 8'b0000_0000;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL midrun_reset: got %b want %b", obs, exp); end
    i_rst = 1'b0; i_en = 1'b0;
    step();
    total++;
    if (obs !== exp) begin bad++; $display("FAIL midrun_idle: got %b want %b", obs, exp); end
    i_en = 1'b1;
    step();
    step();
    exp = 8'b1101_0001;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL midrun_restart: got %b want %b", obs, exp); end
    i_en = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_max_dwell();
    logic [7:0] exp;
    do_reset();
    i_dwell = 4'hF; i_en = 1'b1; i_valid = 1'b1; i_data = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      exp = {4'b1101, (k < 15) ? 4'b0001 : 4'b0010};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL maxdwell_beat%0d: got %b want %b", k, obs, exp); end
    end
    i_en = 1'b0; i_valid = 1'b0;
  endtask

`ifdef DEMUX_SEL_SEQ_SKIP_EN
  task automatic test_skip();
    logic [7:0] exp;
    logic [7:0] seq_e [0:3];
    seq_e[0] = 8'b1101_0010;
    seq_e[1] = 8'b0111_1000;
    seq_e[2] = 8'b1000_0000;
    seq_e[3] = 8'b1101_0010;
    i_skip_mask = 4'b0101;
    do_reset();
    i_dwell = 4'd1; i_en = 1'b1; i_valid = 1'b1; i_data = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      exp = seq_e[k];
      total++;
      if (obs !== exp) begin bad++; $display("FAIL skip_cyc%0d: got %b want %b", k, obs, exp); end
    end
    i_skip_mask = 4'b1111;
    do_reset();
    i_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (o_ready !== 1'b0) begin bad++; $display("FAIL skip_all%0d: got %b want 0", k, o_ready); end
    end
    i_en = 1'b0; i_valid = 1'b0; i_skip_mask = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_dwell_zero();
    test_gapped();
    test_en_drop();
    test_reset_mid_run();
    test_max_dwell();
`ifdef DEMUX_SEL_SEQ_SKIP_EN
    test_skip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
